// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with 2-bit full/empty status words,
// occupancy count and sticky overflow/underflow flags. All outputs are registered.
module fifo_sync #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned ALMOST = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              winc,
  input  logic [DATA_W-1:0] wdata,
  output logic [1:0]        wfull,
  input  logic              rinc,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rempty,
  output logic [ADDR_W:0]   count,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CntZero     = '0;
  localparam logic [ADDR_W:0] CntOne      = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] CntFull     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CntAlmFull  = (ADDR_W + 1)'(DEPTH - ALMOST);
  localparam logic [ADDR_W:0] CntAlmEmpty = (ADDR_W + 1)'(ALMOST);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        wfull_q, wfull_d;
  logic [1:0]        rempty_q, rempty_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_acc, rd_acc;

  always_comb begin
    rd_acc   = rinc && (count_q != CntZero);
    wr_acc   = winc && ((count_q != CntFull) || rd_acc);
    wptr_d   = wptr_q + ADDR_W'(wr_acc);
    rptr_d   = rptr_q + ADDR_W'(rd_acc);

    count_d  = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CntOne;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CntOne;
    end

    // When the FIFO is (or becomes) empty before this write, the new head is
    // the word being written now, which the memory does not hold yet.
    rdata_d = '0;
    if (count_d != CntZero) begin
      if ((count_q == CntZero) || ((count_q == CntOne) && rd_acc)) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem[rptr_d];
      end
    end

    ovf_d = ovf_q || (winc && !wr_acc);
    udf_d = udf_q || (rinc && !rd_acc);

    wfull_d = 2'b00;
    if (count_d == CntFull) begin
      wfull_d = 2'b01;
    end else if (count_d >= CntAlmFull) begin
      wfull_d = 2'b10;
    end

    rempty_d = 2'b00;
    if (count_d == CntZero) begin
      rempty_d = 2'b01;
    end else if (count_d <= CntAlmEmpty) begin
      rempty_d = 2'b10;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      mem[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      wfull_q  <= 2'b00;
      rempty_q <= 2'b01;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign wfull   = wfull_q;
  assign rempty  = rempty_q;
  assign rdata   = rdata_q;
  assign count   = count_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync: reset, fill, drain, overflow,
// simultaneous push/pop at both boundaries and reset mid-run.
module tb_fifo_sync;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        winc = 1'b0;
  logic [23:0] wdata = '0;
  logic        rinc = 1'b0;
  logic [1:0]  wfull;
  logic [23:0] rdata;
  logic [1:0]  rempty;
  logic [4:0]  count;
  logic        ovf_err;
  logic        udf_err;

  int n_cmp = 0;
  int n_err = 0;

  fifo_sync #(
    .DATA_W(24),
    .ADDR_W(4),
    .ALMOST(2)
  ) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .winc   (winc),
    .wdata  (wdata),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty),
    .count  (count),
    .ovf_err(ovf_err),
    .udf_err(udf_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_rempty(input int n);
    if (n == 0) return 2'b01;
    if (n <= 2) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] exp_wfull(input int n);
    if (n == 16) return 2'b01;
    if (n >= 14) return 2'b10;
    return 2'b00;
  endfunction

  // Apply inputs just after an edge, clock once, sample 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [23:0] d);
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    winc = 1'b1;
    rinc = 1'b1;
    wdata = 24'hffffff;
    @(posedge CLK);
    #2;
    winc = 1'b0;
    @(posedge CLK);
    #2;
    rinc = 1'b0;
    winc = 1'b0;
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wfull"}, 32'(wfull), 32'h0);
    check({tag, "_rempty"}, 32'(rempty), 32'h1);
    check({tag, "_rdata"}, 32'(rdata), 32'h0);
    check({tag, "_count"}, 32'(count), 32'h0);
    check({tag, "_ovf"}, 32'(ovf_err), 32'h0);
    check({tag, "_udf"}, 32'(udf_err), 32'h0);
  endtask

  initial begin
    logic [23:0] d;

    // 1: reset held with inputs toggling
    RSTn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      winc = i[0];
      rinc = ~i[0];
      wdata = 24'(i + 1);
      @(posedge CLK);
      #1;
      check_idle("rst_hold");
    end
    winc = 1'b0;
    rinc = 1'b0;
    #3 RSTn = 1'b1;
    @(posedge CLK);
    #1;
    check_idle("rst_rel");

    // 2: fill
    for (int i = 0; i < 16; i++) begin
      d = (i == 0) ? 24'haabbcc : 24'(i);
      step(1'b1, 1'b0, d);
      check($sformatf("fill_count%0d", i), 32'(count), 32'(i + 1));
      check($sformatf("fill_rempty%0d", i), 32'(rempty), 32'(exp_rempty(i + 1)));
      check($sformatf("fill_wfull%0d", i), 32'(wfull), 32'(exp_wfull(i + 1)));
      check($sformatf("fill_rdata%0d", i), 32'(rdata), 32'h00aabbcc);
    end

    // 4: overflow write while full is dropped
    step(1'b1, 1'b0, 24'h11);
    check("ovf_err", 32'(ovf_err), 32'h1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_wfull", 32'(wfull), 32'h1);
    check("ovf_udf", 32'(udf_err), 32'h0);

    // 3: drain in order, no 24'h11 present
    for (int i = 0; i < 16; i++) begin
      d = (i == 0) ? 24'haabbcc : 24'(i);
      check($sformatf("drain_rdata%0d", i), 32'(rdata), 32'(d));
      step(1'b0, 1'b1, 24'h0);
      check($sformatf("drain_count%0d", i), 32'(count), 32'(15 - i));
      check($sformatf("drain_rempty%0d", i), 32'(rempty), 32'(exp_rempty(15 - i)));
      check($sformatf("drain_wfull%0d", i), 32'(wfull), 32'(exp_wfull(15 - i)));
    end
    check("drain_rdata_end", 32'(rdata), 32'h0);
    check("drain_udf_pre", 32'(udf_err), 32'h0);
    step(1'b0, 1'b1, 24'h0);
    check("udf_err", 32'(udf_err), 32'h1);
    check("udf_count", 32'(count), 32'h0);
    check("udf_rempty", 32'(rempty), 32'h1);
    rinc = 1'b0;

    // 5: simultaneous push/pop at full, with pointer wrap
    do_reset();
    check_idle("rst5");
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 24'(32'h100 + i));
    check("sim_fill_count", 32'(count), 32'd16);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sim_full_rdata%0d", k), 32'(rdata), 32'h100 + k);
      step(1'b1, 1'b1, 24'(32'h70 + k));
      check($sformatf("sim_full_count%0d", k), 32'(count), 32'd16);
      check($sformatf("sim_full_wfull%0d", k), 32'(wfull), 32'h1);
      check($sformatf("sim_full_ovf%0d", k), 32'(ovf_err), 32'h0);
    end
    for (int i = 0; i < 16; i++) begin
      d = (i < 13) ? 24'(32'h103 + i) : 24'(32'h70 + i - 13);
      check($sformatf("sim_drain_rdata%0d", i), 32'(rdata), 32'(d));
      step(1'b0, 1'b1, 24'h0);
    end
    check("sim_drain_count", 32'(count), 32'h0);
    rinc = 1'b0;
    #1;
    check("sim_udf_pre", 32'(udf_err), 32'h0);
    // simultaneous at empty: write taken, read rejected
    step(1'b1, 1'b1, 24'h00beef);
    check("sim_empty_count", 32'(count), 32'h1);
    check("sim_empty_udf", 32'(udf_err), 32'h1);
    check("sim_empty_rdata", 32'(rdata), 32'h00beef);
    check("sim_empty_rempty", 32'(rempty), 32'h2);

    // 6: reset mid-run
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 24'(32'h200 + i));
    winc = 1'b0;
    check("mid_count_pre", 32'(count), 32'd7);
    #2 RSTn = 1'b0;
    #1;
    check("mid_rempty", 32'(rempty), 32'h1);
    check("mid_count", 32'(count), 32'h0);
    check("mid_rdata", 32'(rdata), 32'h0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    step(1'b1, 1'b0, 24'h5);
    check("mid_rd_data", 32'(rdata), 32'h5);
    check("mid_rd_count", 32'(count), 32'h1);
    step(1'b0, 1'b1, 24'h0);
    check("mid_pop_count", 32'(count), 32'h0);
    check("mid_pop_rdata", 32'(rdata), 32'h0);
    rinc = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
